fp_mul_sched: RTL

Round-robin scheduler that shares one combinational single-precision multiplier (`fp_mul`) among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one requester at a time and registers the operands into the shared multiplier. It captures the product and returns it on a single response channel tagged with the requester index. It sits between the compute clients and the single `fp_mul` instance, so that only one multiplier is instantiated.

---
 rtl/fp_mul_sched.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fp_mul_sched.sv
// Round-robin arbiter that time-shares one combinational fp_mul among NUM_REQ
// requesters: grant -> registered operands -> captured product -> tagged response.
module fp_mul_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_op1,
  input  logic [32*NUM_REQ-1:0]   req_op2,
  output logic [31:0]             mul_op1,
  output logic [31:0]             mul_op2,
  input  logic [31:0]             mul_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]       mul_op1_q, mul_op1_d;
  logic [31:0]       mul_op2_q, mul_op2_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;

  logic [31:0]       op1_arr [NUM_REQ];
  logic [31:0]       op2_arr [NUM_REQ];
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op1_arr[gi]   = req_op1[32*gi +: 32];
      assign op2_arr[gi]   = req_op2[32*gi +: 32];
      assign req_ready[gi] = grant_en && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W:0] sum;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[sum[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[ID_W-1:0];
      end
    end
  end

  assign grant_en = (state_q == IDLE) && !rst && grant_found;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    mul_op1_d    = mul_op1_q;
    mul_op2_d    = mul_op2_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          mul_op1_d = op1_arr[grant_idx];
          mul_op2_d = op2_arr[grant_idx];
          rsp_id_d  = grant_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = mul_result;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ-1)) ? '0 : rsp_id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      mul_op1_q    <= '0;
      mul_op2_q    <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      mul_op1_q    <= mul_op1_d;
      mul_op2_q    <= mul_op2_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign mul_op1    = mul_op1_q;
  assign mul_op2    = mul_op2_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_valid  = rsp_valid_q;
  assign busy       = busy_q;

endmodule
